// File: rtl/apb_bridge_controller.sv
// AHB-to-APB bridge sequencing FSM.
// Drives the APB setup and enable phases from the pipelined AHB beat registers.
// Stalls the AHB master through hready_out while the next beat cannot be taken.
module apb_bridge_controller (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        valid,
  input  logic        hwrite,
  input  logic        hwrite_reg,
  input  logic [31:0] haddr,
  input  logic [31:0] haddr1,
  input  logic [31:0] haddr2,
  input  logic [31:0] hwdata,
  input  logic [31:0] hwdata1,
  output logic [2:0]  pselx,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        hready_out
);

  typedef enum logic [2:0] {
    IDLE, WWAIT, READ, WRITE, WRITEP, RENABLE, WENABLE, WENABLEP
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_pselx, w_pselx;
  logic        r_penable, w_penable;
  logic        r_pwrite, w_pwrite;
  logic [31:0] r_paddr, w_paddr;
  logic [31:0] r_pwdata, w_pwdata;
  logic        r_hready, w_hready;

  // Three 64 MB peripheral windows starting at 0x8000_0000; anything else selects nothing.
  function automatic logic [2:0] f_decode(input logic [31:0] a);
    case (a[31:26])
      6'b100000: f_decode = 3'b001;
      6'b100001: f_decode = 3'b010;
      6'b100010: f_decode = 3'b100;
      default:   f_decode = 3'b000;
    endcase
  endfunction

  // Next state, then the output values loaded on the edge that enters it.
  always_comb begin
    w_state_nxt = r_state;
    w_pselx     = r_pselx;
    w_penable   = r_penable;
    w_pwrite    = r_pwrite;
    w_paddr     = r_paddr;
    w_pwdata    = r_pwdata;
    w_hready    = r_hready;

    case (r_state)
      IDLE, RENABLE, WENABLE: begin
        if (valid && hwrite)  w_state_nxt = WWAIT;
        else if (valid)       w_state_nxt = READ;
        else                  w_state_nxt = IDLE;
      end
      WWAIT:    w_state_nxt = valid ? WRITEP : WRITE;
      READ:     w_state_nxt = RENABLE;
      WRITE:    w_state_nxt = valid ? WENABLEP : WENABLE;
      WRITEP:   w_state_nxt = WENABLEP;
      WENABLEP: begin
        if (!hwrite_reg)      w_state_nxt = READ;
        else if (valid)       w_state_nxt = WRITEP;
        else                  w_state_nxt = WRITE;
      end
      default:  w_state_nxt = IDLE;
    endcase

    case (w_state_nxt)
      READ: begin
        // Coming out of the write pipeline the read beat is two cycles old.
        w_paddr   = (r_state == WENABLEP) ? haddr2 : haddr;
        w_pselx   = f_decode(w_paddr);
        w_pwrite  = 1'b0;
        w_penable = 1'b0;
        w_hready  = 1'b0;
      end
      WRITE, WRITEP: begin
        if (r_state == WWAIT) begin
          w_paddr  = haddr1;
          w_pwdata = hwdata;
        end else begin
          w_paddr  = haddr2;
          w_pwdata = hwdata1;
        end
        w_pselx   = f_decode(w_paddr);
        w_pwrite  = 1'b1;
        w_penable = 1'b0;
        // Pipelined write holds the master one cycle so the beat registers stay aligned.
        w_hready  = (w_state_nxt == WRITE);
      end
      RENABLE, WENABLE, WENABLEP: begin
        w_penable = 1'b1;
        w_hready  = 1'b1;
      end
      default: begin
        w_pselx   = 3'b000;
        w_penable = 1'b0;
        w_hready  = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Registered APB outputs.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_pselx   <= 3'b000;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= 32'h0;
      r_pwdata  <= 32'h0;
      r_hready  <= 1'b1;
    end else begin
      r_pselx   <= w_pselx;
      r_penable <= w_penable;
      r_pwrite  <= w_pwrite;
      r_paddr   <= w_paddr;
      r_pwdata  <= w_pwdata;
      r_hready  <= w_hready;
    end
  end

  assign pselx      = r_pselx;
  assign penable    = r_penable;
  assign pwrite     = r_pwrite;
  assign paddr      = r_paddr;
  assign pwdata     = r_pwdata;
  assign hready_out = r_hready;

endmodule

// File: tb/tb_apb_bridge_controller.sv
// Scoreboard bench for apb_bridge_controller: stimulus queues the expected APB
// transfer, a monitor checks each enable phase against the queue head.
module tb_apb_bridge_controller;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        valid, hwrite, hwrite_reg;
  logic [31:0] haddr, haddr1, haddr2, hwdata, hwdata1;
  logic [2:0]  pselx;
  logic        penable, pwrite, hready_out;
  logic [31:0] paddr, pwdata;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    logic [2:0]  psel;
  } xfer_t;

  xfer_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    hr_low  = 0;

  always #5 hclk = ~hclk;

  apb_bridge_controller dut (
    .hclk(hclk), .hreset(hreset), .valid(valid), .hwrite(hwrite),
    .hwrite_reg(hwrite_reg), .haddr(haddr), .haddr1(haddr1), .haddr2(haddr2),
    .hwdata(hwdata), .hwdata1(hwdata1), .pselx(pselx), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .hready_out(hready_out)
  );

  // AHB slave-side pipeline registers feeding the controller.
  always @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      haddr1 <= 32'h0; haddr2 <= 32'h0; hwdata1 <= 32'h0; hwrite_reg <= 1'b0;
    end else begin
      haddr1 <= haddr; haddr2 <= haddr1; hwdata1 <= hwdata; hwrite_reg <= hwrite;
    end
  end

  // Monitor: each enable phase pops one expected transfer and checks its setup cycle.
  logic        prev_en;
  logic [2:0]  prev_psel;
  logic [31:0] prev_addr;
  always @(negedge hclk) begin
    xfer_t e;
    if (hreset) begin
      prev_en = 1'b0; prev_psel = 3'b0; prev_addr = 32'h0;
    end else begin
      if (!hready_out) hr_low++;
      if (penable) begin
        n_tests++;
        if (prev_en || prev_psel != pselx || prev_addr != paddr) begin
          n_fail++;
          $display("FAIL setup_phase: prev_en=%0b prev_psel=%b prev_addr=%h, want en=0 psel=%b addr=%h",
                   prev_en, prev_psel, prev_addr, pselx, paddr);
        end
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_xfer: got addr=%h psel=%b, want none", paddr, pselx);
        end else begin
          e = exp_q.pop_front();
          if (pselx != e.psel || paddr != e.addr || pwrite != e.wr || (e.wr && pwdata != e.data)) begin
            n_fail++;
            $display("FAIL xfer: got psel=%b addr=%h wr=%0b data=%h, want psel=%b addr=%h wr=%0b data=%h",
                     pselx, paddr, pwrite, pwdata, e.psel, e.addr, e.wr, e.data);
          end
        end
      end
      prev_en = penable; prev_psel = pselx; prev_addr = paddr;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [2:0] s);
    xfer_t x;
    x.addr = a; x.data = d; x.wr = w; x.psel = s;
    exp_q.push_back(x);
  endtask

  task automatic idle_in();
    valid = 1'b0; hwrite = 1'b0; haddr = 32'h0; hwdata = 32'h0;
  endtask

  int base;

  initial begin
    idle_in();
    hreset = 1'b1;
    #12;
    chk("rst_pselx",   {29'h0, pselx}, 32'h0);
    chk("rst_penable", {31'h0, penable}, 32'h0);
    chk("rst_pwrite",  {31'h0, pwrite}, 32'h0);
    chk("rst_paddr",   paddr, 32'h0);
    chk("rst_pwdata",  pwdata, 32'h0);
    chk("rst_hready",  {31'h0, hready_out}, 32'h1);
    hreset = 1'b0;
    cyc(2);

    // Single read.
    base = hr_low;
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h8400_0010;
    push(32'h8400_0010, 32'h0, 1'b0, 3'b010);
    cyc();
    idle_in();
    chk("rd_setup_psel",   {29'h0, pselx}, 32'h2);
    chk("rd_setup_en",     {31'h0, penable}, 32'h0);
    chk("rd_setup_hready", {31'h0, hready_out}, 32'h0);
    cyc();
    chk("rd_enable_hready", {31'h0, hready_out}, 32'h1);
    cyc();
    chk("rd_idle_psel", {29'h0, pselx}, 32'h0);
    cyc(2);
    chk("rd_hready_lows", hr_low - base, 1);

    // Single write.
    base = hr_low;
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8000_0004;
    push(32'h8000_0004, 32'hDEAD_BEEF, 1'b1, 3'b001);
    cyc();
    valid = 1'b0; hwrite = 1'b0; haddr = 32'h0; hwdata = 32'hDEAD_BEEF;
    cyc();
    hwdata = 32'h0;
    cyc(4);
    chk("wr_hready_lows", hr_low - base, 0);

    // Back-to-back writes: WWAIT->WRITEP->WENABLEP->WRITE->WENABLE.
    base = hr_low;
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8800_0000;
    push(32'h8800_0000, 32'h1111_0000, 1'b1, 3'b100);
    cyc();
    haddr = 32'h8800_0004; hwdata = 32'h1111_0000;
    push(32'h8800_0004, 32'h2222_0004, 1'b1, 3'b100);
    cyc();
    valid = 1'b0; hwdata = 32'h2222_0004;
    cyc();
    idle_in();
    cyc(5);
    chk("b2b_hready_lows", hr_low - base, 1);

    // Write followed by a read: WENABLEP->READ with the read address from haddr2.
    base = hr_low;
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8000_0100;
    push(32'h8000_0100, 32'hCAFE_0001, 1'b1, 3'b001);
    cyc();
    hwrite = 1'b0; haddr = 32'h8400_0200; hwdata = 32'hCAFE_0001;
    push(32'h8400_0200, 32'h0, 1'b0, 3'b010);
    cyc();
    idle_in();
    cyc(5);
    chk("wr_rd_hready_lows", hr_low - base, 2);

    // Unmapped address: no select, phases still complete.
    base = hr_low;
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h8C00_0000;
    push(32'h8C00_0000, 32'h0, 1'b0, 3'b000);
    cyc();
    idle_in();
    cyc(4);
    chk("unmapped_hready_lows", hr_low - base, 1);
    chk("queue_drained", exp_q.size(), 0);

    // Reset asserted mid-WENABLE abandons the transfer (nothing queued).
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8000_0008;
    cyc();
    valid = 1'b0; hwrite = 1'b0; haddr = 32'h0; hwdata = 32'h5555_AAAA;
    cyc();
    hwdata = 32'h0;
    cyc();
    chk("pre_rst_en", {31'h0, penable}, 32'h1);
    #1 hreset = 1'b1;
    #1;
    chk("mid_rst_en",     {31'h0, penable}, 32'h0);
    chk("mid_rst_psel",   {29'h0, pselx}, 32'h0);
    chk("mid_rst_hready", {31'h0, hready_out}, 32'h1);
    chk("mid_rst_paddr",  paddr, 32'h0);
    cyc();
    hreset = 1'b0;
    cyc(3);
    chk("post_rst_psel", {29'h0, pselx}, 32'h0);
    chk("post_rst_en",   {31'h0, penable}, 32'h0);
    chk("post_rst_hready", {31'h0, hready_out}, 32'h1);
    chk("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
